// File: rtl/m_lsu.sv
// m_lsu: memory-stage load/store unit. Checks the effective address, runs a
// single-outstanding req/ack bus transaction, stalls the pipe while it is in
// flight and hands the extended load value to the W stage.
module m_lsu #(
   parameter logic [31:0] DM_TOP   = 32'h0000_2FFF,
   parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
   parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
   parameter logic [31:0] INT_BASE = 32'h0000_7F20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_i,
   input  logic [3:0]  mem_op,
   input  logic [31:0] addr,
   input  logic        ov_dm,
   input  logic [31:0] wdata,
   input  logic        flush,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        exc_valid,
   output logic [4:0]  exc_code
);
   localparam logic [3:0] OP_LW  = 4'd1, OP_LH  = 4'd2, OP_LHU = 4'd3,
                          OP_LB  = 4'd4, OP_LBU = 4'd5, OP_SW  = 4'd6,
                          OP_SH  = 4'd7, OP_SB  = 4'd8;
   localparam logic [4:0] EXC_ADEL = 5'd4, EXC_ADES = 5'd5;

   typedef enum logic [1:0] {IDLE, WAIT, DONE, DROP} state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_req_t;

   state_t      state, state_nxt;
   bus_req_t    req_d, req_q;
   logic        req_vld_q;
   logic [3:0]  op_q;
   logic [1:0]  lo_q;
   logic        accept;

   logic is_ld, is_st, is_w, is_h, active;
   logic in_dm, in_tc0, in_tc1, in_int, in_dev, misal, bad;

   // Sign/zero-extend the lane picked by the latched low address bits.
   function automatic logic [31:0] ld_ext(input logic [3:0] op, input logic [1:0] lo,
                                          input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*lo +: 8];
      h = lo[1] ? w[31:16] : w[15:0];
      case (op)
         OP_LB:   ld_ext = {{24{b[7]}}, b};
         OP_LBU:  ld_ext = {24'd0, b};
         OP_LH:   ld_ext = {{16{h[15]}}, h};
         OP_LHU:  ld_ext = {16'd0, h};
         default: ld_ext = w;
      endcase
   endfunction

   // Decode the access and evaluate every address-error condition.
   always_comb begin
      is_ld  = (mem_op >= OP_LW) && (mem_op <= OP_LBU);
      is_st  = (mem_op >= OP_SW) && (mem_op <= OP_SB);
      is_w   = (mem_op == OP_LW) || (mem_op == OP_SW);
      is_h   = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
      active = valid_i && (is_ld || is_st) && !flush;
      in_dm  = addr <= DM_TOP;
      in_tc0 = (addr >= TC0_BASE) && (addr <= TC0_BASE + 32'd11);
      in_tc1 = (addr >= TC1_BASE) && (addr <= TC1_BASE + 32'd11);
      in_int = (addr >= INT_BASE) && (addr <= INT_BASE + 32'd3);
      in_dev = in_tc0 || in_tc1 || in_int;
      misal  = (is_w && (addr[1:0] != 2'b00)) || (is_h && addr[0]);
      // Devices are word-only and their count registers are read-only.
      bad    = ov_dm || misal || !(in_dm || in_dev) || (in_dev && !is_w) ||
               (is_st && ((addr == TC0_BASE + 32'd8) || (addr == TC1_BASE + 32'd8)));
   end

   // Build the bus request from the current M-stage instruction.
   always_comb begin
      req_d       = '0;
      req_d.we    = is_st;
      req_d.addr  = {addr[31:2], 2'b00};
      if (is_w)      req_d.be = 4'b1111;
      else if (is_h) req_d.be = addr[1] ? 4'b1100 : 4'b0011;
      else           req_d.be = 4'b0001 << addr[1:0];
      case (mem_op)
         OP_SW:   req_d.wdata = wdata;
         OP_SH:   req_d.wdata = {2{wdata[15:0]}};
         OP_SB:   req_d.wdata = {4{wdata[7:0]}};
         default: req_d.wdata = '0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state, stall and exception reporting.
   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      exc_valid = 1'b0;
      exc_code  = 5'd0;
      accept    = 1'b0;
      case (state)
         IDLE: if (active) begin
            if (bad) begin
               exc_valid = 1'b1;
               exc_code  = is_st ? EXC_ADES : EXC_ADEL;
            end else begin
               accept    = 1'b1;
               stall     = 1'b1;
               state_nxt = WAIT;
            end
         end
         // A flushed transaction still has to finish on the bus.
         WAIT: begin
            stall = !flush;
            if (bus_ack)    state_nxt = flush ? IDLE : DONE;
            else if (flush) state_nxt = DROP;
         end
         DROP: if (bus_ack) state_nxt = IDLE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (!reset) begin
         stall     = 1'b0;
         exc_valid = 1'b0;
         exc_code  = 5'd0;
         accept    = 1'b0;
      end
   end

   // Request latch, bus field clearing on ack, load result capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_q       <= '0;
         req_vld_q   <= 1'b0;
         op_q        <= 4'd0;
         lo_q        <= 2'd0;
         rdata       <= 32'd0;
         rdata_valid <= 1'b0;
      end else begin
         rdata_valid <= 1'b0;
         if (accept) begin
            req_q     <= req_d;
            req_vld_q <= 1'b1;
            op_q      <= mem_op;
            lo_q      <= addr[1:0];
         end else if (((state == WAIT) || (state == DROP)) && bus_ack) begin
            req_q     <= '0;
            req_vld_q <= 1'b0;
            if ((state == WAIT) && !flush && !req_q.we) begin
               rdata       <= ld_ext(op_q, lo_q, bus_rdata);
               rdata_valid <= 1'b1;
            end
         end
      end
   end

   assign bus_req   = req_vld_q;
   assign bus_we    = req_q.we;
   assign bus_addr  = req_q.addr;
   assign bus_be    = req_q.be;
   assign bus_wdata = req_q.wdata;
endmodule

// File: tb/tb_m_lsu.sv
// tb_m_lsu: directed vectors for m_lsu with hand-computed expectations.
module tb_m_lsu;
   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i, ov_dm, flush, bus_ack;
   logic [3:0]  mem_op;
   logic [31:0] addr, wdata, bus_rdata;
   logic        bus_req, bus_we, stall, rdata_valid, exc_valid;
   logic [31:0] bus_addr, bus_wdata, rdata;
   logic [3:0]  bus_be;
   logic [4:0]  exc_code;

   int n_cmp = 0;
   int n_err = 0;

   m_lsu dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .mem_op(mem_op), .addr(addr),
      .ov_dm(ov_dm), .wdata(wdata), .flush(flush), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_ack(bus_ack), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
      .exc_valid(exc_valid), .exc_code(exc_code)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Full access; called just after a rising edge with the unit in IDLE.
   task automatic access(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int extra,
                         input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wd, input logic e_we,
                         input logic [31:0] e_rd, input logic e_rv);
      valid_i = 1'b1; mem_op = op; addr = a; wdata = wd; ov_dm = 1'b0;
      @(negedge clk);
      chk({tag, " idle stall"}, stall, 1);
      chk({tag, " idle exc"}, exc_valid, 0);
      @(posedge clk); #1;
      for (int i = 0; i < extra; i++) begin
         @(negedge clk);
         chk({tag, " wait stall"}, stall, 1);
         chk({tag, " wait req"}, bus_req, 1);
         chk({tag, " wait addr"}, bus_addr, e_addr);
         @(posedge clk); #1;
      end
      bus_ack = 1'b1; bus_rdata = rd;
      @(negedge clk);
      chk({tag, " req"}, bus_req, 1);
      chk({tag, " we"}, bus_we, e_we);
      chk({tag, " addr"}, bus_addr, e_addr);
      chk({tag, " be"}, bus_be, e_be);
      chk({tag, " wdata"}, bus_wdata, e_wd);
      chk({tag, " ack stall"}, stall, 1);
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_rdata = 32'd0;
      @(negedge clk);
      chk({tag, " done stall"}, stall, 0);
      chk({tag, " done req"}, bus_req, 0);
      chk({tag, " done be"}, bus_be, 0);
      chk({tag, " rvalid"}, rdata_valid, e_rv);
      if (e_rv) chk({tag, " rdata"}, rdata, e_rd);
      @(posedge clk); #1;
      valid_i = 1'b0; mem_op = 4'd0;
      @(negedge clk);
      chk({tag, " after rvalid"}, rdata_valid, 0);
      @(posedge clk); #1;
   endtask

   // Access that must raise an exception in the same cycle and never hit the bus.
   task automatic excp(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic ov, input logic [4:0] code);
      valid_i = 1'b1; mem_op = op; addr = a; ov_dm = ov; wdata = 32'h1234_5678;
      @(negedge clk);
      chk({tag, " exc"}, exc_valid, 1);
      chk({tag, " code"}, exc_code, code);
      chk({tag, " stall"}, stall, 0);
      @(posedge clk); #1;
      valid_i = 1'b0; mem_op = 4'd0; ov_dm = 1'b0;
      @(negedge clk);
      chk({tag, " no req"}, bus_req, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b0; valid_i = 1'b1; mem_op = 4'd1; addr = 32'h2; ov_dm = 1'b0;
      wdata = 32'd0; flush = 1'b0; bus_rdata = 32'd0; bus_ack = 1'b0;
      @(negedge clk);
      chk("rst req", bus_req, 0);
      chk("rst we", bus_we, 0);
      chk("rst addr", bus_addr, 0);
      chk("rst be", bus_be, 0);
      chk("rst wdata", bus_wdata, 0);
      chk("rst rdata", rdata, 0);
      chk("rst rvalid", rdata_valid, 0);
      chk("rst stall", stall, 0);
      chk("rst exc", exc_valid, 0);
      valid_i = 1'b0; mem_op = 4'd0; addr = 32'd0;
      reset = 1'b1;
      @(posedge clk); #1;

      access("LW",  4'd1, 32'h10,   0, 32'hDEADBEEF, 0, 32'h10, 4'b1111, 0, 0, 32'hDEADBEEF, 1);
      access("LB",  4'd4, 32'h13,   0, 32'h80112233, 0, 32'h10, 4'b1000, 0, 0, 32'hFFFFFF80, 1);
      access("LBU", 4'd5, 32'h13,   0, 32'h80112233, 0, 32'h10, 4'b1000, 0, 0, 32'h00000080, 1);
      access("LH",  4'd2, 32'h12,   0, 32'h80112233, 0, 32'h10, 4'b1100, 0, 0, 32'hFFFF8011, 1);
      access("LHU", 4'd3, 32'h12,   0, 32'h80112233, 1, 32'h10, 4'b1100, 0, 0, 32'h00008011, 1);
      access("LH0", 4'd2, 32'h14,   0, 32'h0000F00D, 0, 32'h14, 4'b0011, 0, 0, 32'hFFFFF00D, 1);
      access("SB",  4'd8, 32'h21,   32'h000000AB, 0, 0, 32'h20, 4'b0010, 32'hABABABAB, 1, 0, 0);
      access("SH",  4'd7, 32'h22,   32'h00001234, 0, 0, 32'h20, 4'b1100, 32'h12341234, 1, 0, 0);
      access("SW",  4'd6, 32'h2FFC, 32'hCAFEF00D, 0, 1, 32'h2FFC, 4'b1111, 32'hCAFEF00D, 1, 0, 0);
      access("LWT", 4'd1, 32'h7F08, 0, 32'h00000005, 2, 32'h7F08, 4'b1111, 0, 0, 32'h00000005, 1);

      excp("LW mis",  4'd1, 32'h2,    1'b0, 5'd4);
      excp("SW cnt",  4'd6, 32'h7F08, 1'b0, 5'd5);
      excp("SH tc0",  4'd7, 32'h7F00, 1'b0, 5'd5);
      excp("LW oor",  4'd1, 32'h3000, 1'b0, 5'd4);
      excp("SW ov",   4'd6, 32'h40,   1'b1, 5'd5);
      excp("LB int",  4'd4, 32'h7F20, 1'b0, 5'd4);
      excp("LW gap",  4'd1, 32'h7F0C, 1'b0, 5'd4);
      excp("LH mis",  4'd2, 32'h11,   1'b0, 5'd4);

      // Flush in IDLE hides both the exception and the request.
      valid_i = 1'b1; mem_op = 4'd1; addr = 32'h2; flush = 1'b1;
      @(negedge clk);
      chk("iflush exc", exc_valid, 0);
      chk("iflush stall", stall, 0);
      @(posedge clk); #1;
      valid_i = 1'b0; mem_op = 4'd0; flush = 1'b0;
      @(negedge clk);
      chk("iflush req", bus_req, 0);
      @(posedge clk); #1;

      // Flush during a three-cycle WAIT: bus finishes, result discarded.
      valid_i = 1'b1; mem_op = 4'd1; addr = 32'h20;
      @(negedge clk);
      chk("fl idle stall", stall, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("fl w1 req", bus_req, 1);
      chk("fl w1 stall", stall, 1);
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      chk("fl w2 stall", stall, 0);
      chk("fl w2 req", bus_req, 1);
      @(posedge clk); #1;
      flush = 1'b0; valid_i = 1'b0; mem_op = 4'd0;
      bus_ack = 1'b1; bus_rdata = 32'h55AA55AA;
      @(negedge clk);
      chk("fl drop req", bus_req, 1);
      chk("fl drop addr", bus_addr, 32'h20);
      chk("fl drop stall", stall, 0);
      @(posedge clk); #1;
      bus_ack = 1'b0;
      @(negedge clk);
      chk("fl end req", bus_req, 0);
      chk("fl end rvalid", rdata_valid, 0);
      chk("fl end rdata", rdata, 32'h00000005);
      @(posedge clk); #1;

      // Reset while waiting on the bus.
      valid_i = 1'b1; mem_op = 4'd1; addr = 32'h30;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rw req", bus_req, 1);
      #1 reset = 1'b0;
      #1;
      chk("rw req0", bus_req, 0);
      chk("rw addr0", bus_addr, 0);
      chk("rw be0", bus_be, 0);
      chk("rw stall0", stall, 0);
      chk("rw rdata0", rdata, 0);
      valid_i = 1'b0; mem_op = 4'd0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      access("LW rst", 4'd1, 32'h30, 0, 32'h01234567, 0, 32'h30, 4'b1111, 0, 0, 32'h01234567, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
